// File: rtl/garage_door_plant.sv
// Behavioural plant model of a motorised garage door.
// The controller drives raise/lower motor commands; the plant integrates them
// into a door position (one step every STEP_DIV clocks) and reports the limit
// switches. Asserting both commands together latches a FAULT, which only
// fault_clr releases. An obstruction stalls travel without leaving the motion
// state, so the step prescaler resumes exactly where it stopped.
module garage_door_plant #(
   parameter int TRAVEL    = 100,  // steps from fully closed to fully open, 1..255
   parameter int STEP_DIV  = 4,    // clock cycles per position step, 1..255
   parameter bit INIT_OPEN = 1'b0  // 1: door comes out of reset fully open
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up_m,
   input  logic       dn_m,
   input  logic       obstruct,
   input  logic       fault_clr,
   output logic       up_max,
   output logic       dn_max,
   output logic [7:0] pos,
   output logic       moving,
   output logic       fault
);

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RISE  = 2'd1,
      FALL  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [7:0] POS_MAX  = 8'(TRAVEL);
   localparam logic [7:0] PSC_LAST = 8'(STEP_DIV - 1);
   localparam logic [7:0] POS_RST  = INIT_OPEN ? POS_MAX : 8'd0;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pos_nxt;
   logic [7:0] psc;
   logic [7:0] psc_nxt;
   logic       both_m;
   logic       step_due;

   // Both motors energised at once is the illegal command that trips FAULT.
   assign both_m   = up_m & dn_m;
   // The prescaler has reached its last count: this cycle moves the door.
   assign step_due = (psc == PSC_LAST);

   // State register: FSM state, door position and step prescaler.
   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= STOP;
         pos   <= POS_RST;
         psc   <= 8'd0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
         psc   <= psc_nxt;
      end
   end

   // Next-state logic: transitions, position stepping and prescaler update.
   always_comb begin
      // NOTE: every target gets a default before the case, so no path can
      // leave a value unassigned and infer a latch.
      state_nxt = state;
      pos_nxt   = pos;
      psc_nxt   = psc;

      unique case (state)
         STOP: begin
            psc_nxt = 8'd0;
            if (both_m) begin
               state_nxt = FAULT;
            end else if (up_m && (pos < POS_MAX)) begin
               state_nxt = RISE;
            end else if (dn_m && (pos != 8'd0)) begin
               state_nxt = FALL;
            end
         end

         RISE: begin
            if (both_m) begin
               state_nxt = FAULT;
               psc_nxt   = 8'd0;
            end else if (!up_m) begin
               // Released, or reversed (dn_m alone): both park in STOP for one
               // cycle so a reversal restarts the prescaler from zero.
               state_nxt = STOP;
               psc_nxt   = 8'd0;
            end else if (obstruct) begin
               // Stalled: hold position and prescaler, stay in RISE.
               state_nxt = RISE;
            end else if (pos >= POS_MAX) begin
               // Already at the top; never step past the limit.
               state_nxt = STOP;
               psc_nxt   = 8'd0;
            end else if (step_due) begin
               pos_nxt = pos + 8'd1;
               psc_nxt = 8'd0;
               if (pos == (POS_MAX - 8'd1)) begin
                  state_nxt = STOP;
               end
            end else begin
               psc_nxt = psc + 8'd1;
            end
         end

         FALL: begin
            if (both_m) begin
               state_nxt = FAULT;
               psc_nxt   = 8'd0;
            end else if (!dn_m) begin
               // Released, or reversed (up_m alone): one STOP cycle first.
               state_nxt = STOP;
               psc_nxt   = 8'd0;
            end else if (obstruct) begin
               state_nxt = FALL;
            end else if (pos == 8'd0) begin
               // Already at the bottom; never wrap below zero.
               state_nxt = STOP;
               psc_nxt   = 8'd0;
            end else if (step_due) begin
               pos_nxt = pos - 8'd1;
               psc_nxt = 8'd0;
               if (pos == 8'd1) begin
                  state_nxt = STOP;
               end
            end else begin
               psc_nxt = psc + 8'd1;
            end
         end

         FAULT: begin
            // Sticky until an explicit clear that is not itself illegal.
            psc_nxt = 8'd0;
            if (fault_clr && !both_m) begin
               state_nxt = STOP;
            end
         end

         default: begin
            state_nxt = STOP;
            psc_nxt   = 8'd0;
         end
      endcase
   end

   // Output decode: status flags from the state, limit switches from pos.
   always_comb begin
      moving = (state == RISE) || (state == FALL);
      fault  = (state == FAULT);
      up_max = (pos == POS_MAX);
      dn_max = (pos == 8'd0);
   end

   // Position can never leave the physical travel range.
   a_pos_range: assert property (@(posedge clk) disable iff (!rst)
      pos <= POS_MAX);

   // The prescaler never counts past its last value.
   a_psc_range: assert property (@(posedge clk) disable iff (!rst)
      psc <= PSC_LAST);

   // Outside motion the prescaler is always parked at zero.
   a_psc_idle: assert property (@(posedge clk) disable iff (!rst)
      !moving |-> (psc == 8'd0));

endmodule

// File: tb/tb_garage_door_plant.sv
// Self-checking bench for garage_door_plant with TRAVEL=8, STEP_DIV=2,
// INIT_OPEN=0. Each scenario task pushes the expected outputs for a cycle
// onto a queue as it drives that cycle, then pops and compares them against
// the outputs captured after the edge.
module tb_garage_door_plant;

   localparam int TRAVEL   = 8;
   localparam int STEP_DIV = 2;

   logic       clk;
   logic       rst;
   logic       up_m;
   logic       dn_m;
   logic       obstruct;
   logic       fault_clr;
   logic       up_max;
   logic       dn_max;
   logic [7:0] pos;
   logic       moving;
   logic       fault;

   typedef struct packed {
      logic [7:0] pos;
      logic       up_max;
      logic       dn_max;
      logic       moving;
      logic       fault;
   } snap_t;

   typedef struct {
      string tag;
      snap_t v;
   } exp_t;

   exp_t  exp_q[$];
   snap_t got_q[$];
   int    checks = 0;
   int    errors = 0;

   garage_door_plant #(
      .TRAVEL   (TRAVEL),
      .STEP_DIV (STEP_DIV),
      .INIT_OPEN(1'b0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .up_m     (up_m),
      .dn_m     (dn_m),
      .obstruct (obstruct),
      .fault_clr(fault_clr),
      .up_max   (up_max),
      .dn_max   (dn_max),
      .pos      (pos),
      .moving   (moving),
      .fault    (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected snapshot: limit switches follow directly from the position.
   function automatic snap_t mk(input int p, input bit mov, input bit flt);
      snap_t s;
      s.pos    = 8'(p);
      s.up_max = (p == TRAVEL);
      s.dn_max = (p == 0);
      s.moving = mov;
      s.fault  = flt;
      return s;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("pos=%0d up_max=%b dn_max=%b moving=%b fault=%b",
                       s.pos, s.up_max, s.dn_max, s.moving, s.fault);
   endfunction

   task automatic want(input string tag, input int p, input bit mov, input bit flt);
      exp_t e;
      e.tag = tag;
      e.v   = mk(p, mov, flt);
      exp_q.push_back(e);
   endtask

   task automatic grab();
      snap_t s;
      s.pos    = pos;
      s.up_max = up_max;
      s.dn_max = dn_max;
      s.moving = moving;
      s.fault  = fault;
      got_q.push_back(s);
   endtask

   // Drive one cycle of inputs between edges, then capture outputs 1 unit
   // after the rising edge.
   task automatic tick(input logic u, input logic d, input logic o, input logic c);
      up_m      = u;
      dn_m      = d;
      obstruct  = o;
      fault_clr = c;
      @(posedge clk);
      #1;
      grab();
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      up_m      = 1'b0;
      dn_m      = 1'b0;
      obstruct  = 1'b0;
      fault_clr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Raise from closed for n edges (n <= 16): RISE after edge 1, then one
   // step every STEP_DIV edges.
   task automatic rise_to(input int n);
      for (int k = 1; k <= n; k++) begin
         want($sformatf("rise_e%0d", k), (k - 1) / STEP_DIV, 1'b1, 1'b0);
         tick(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      exp_t  e;
      snap_t g;
      rst       = 1'b0;
      up_m      = 1'b0;
      dn_m      = 1'b0;
      obstruct  = 1'b0;
      fault_clr = 1'b0;
      #2;
      want("reset_active", 0, 1'b0, 1'b0);
      grab();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         want($sformatf("idle_%0d", i), 0, 1'b0, 1'b0);
         tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         want($sformatf("dn_at_closed_%0d", i), 0, 1'b0, 1'b0);
         tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   task automatic test_rise();
      exp_t  e;
      snap_t g;
      int    p;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         p = (k - 1) / STEP_DIV;
         if (p > TRAVEL) p = TRAVEL;
         want($sformatf("full_rise_e%0d", k), p, (k <= 16), 1'b0);
         tick(1'b1, 1'b0, 1'b0, 1'b0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   task automatic test_reverse();
      exp_t  e;
      snap_t g;
      do_reset();
      rise_to(9);
      want("rev_stop", 4, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("rev_fall_entry", 4, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 1; j <= 9; j++) begin
         want($sformatf("rev_fall_j%0d", j), 4 - j / STEP_DIV, (j < 8), 1'b0);
         tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   task automatic test_obstruct();
      exp_t  e;
      snap_t g;
      do_reset();
      rise_to(13);
      want("obs_stop", 6, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("obs_fall_entry", 6, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("obs_psc1", 6, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("obs_pos5", 5, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("obs_pos5_psc1", 5, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         want($sformatf("obs_stall_%0d", i), 5, 1'b1, 1'b0);
         tick(1'b0, 1'b1, 1'b1, 1'b0);
      end
      // Prescaler was at its last count before the stall: first edge steps.
      want("obs_resume_step", 4, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("obs_resume_psc1", 4, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("obs_resume_pos3", 3, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   task automatic test_fault();
      exp_t  e;
      snap_t g;
      do_reset();
      rise_to(7);
      want("flt_enter", 3, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         want($sformatf("flt_hold_%0d", i), 3, 1'b0, 1'b1);
         tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
      want("flt_sticky_up", 3, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      want("flt_clr_blocked", 3, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      want("flt_clear", 3, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      want("clr_in_stop", 3, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      want("flt_from_stop", 3, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      want("flt_clear2", 3, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      want("fall_entry", 3, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      want("fall_psc1", 3, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      // A step is due this edge, but the illegal command wins and freezes pos.
      want("flt_priority", 3, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   task automatic test_stop_resume();
      exp_t  e;
      snap_t g;
      do_reset();
      rise_to(6);
      want("release_stop", 2, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      want("resume_entry", 2, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      want("resume_psc1", 2, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      want("resume_pos3", 3, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t  e;
      snap_t g;
      do_reset();
      rise_to(13);
      want("pre_rst_rise", 6, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      want("async_rst_now", 0, 1'b0, 1'b0);
      grab();
      @(posedge clk);
      #1;
      want("rst_held", 0, 1'b0, 1'b0);
      grab();
      rst = 1'b1;
      want("first_edge_after_rst", 0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e.v) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", e.tag, fmt(g), fmt(e.v));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_rise();
      test_reverse();
      test_obstruct();
      test_fault();
      test_stop_resume();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
